// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - CPU FSM state encodings shared by the sequencer, its interface and the control unit
package cpu_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH      = 3'b000,
    DECODE     = 3'b001,
    EXECUTE    = 3'b010,
    MEMORY     = 3'b011,
    WRITEBACK  = 3'b100,
    HALT_STATE = 3'b101,
    IDLE       = 3'b110,
    ILLEGAL    = 3'b111
  } cpu_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control-unit to sequencer bus (proposed state in, registered state and strobes out)
interface cpu_sequencer_if #(
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic [STATE_W-1:0] next_state;
  logic               halt;
  logic               mem_ready;
  logic               run;
  logic               step;
  logic [STATE_W-1:0] state;
  logic               mem_req;
  logic               advance;
  logic               idle;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   instr_count;

  // control unit / debug side
  modport master (
    output next_state, halt, mem_ready, run, step,
    input  state, mem_req, advance, idle, halted, fault, instr_count
  );

  // sequencer side
  modport slave (
    input  next_state, halt, mem_ready, run, step,
    output state, mem_req, advance, idle, halted, fault, instr_count
  );

endinterface

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - memory wait-state watchdog, used only when CPU_SEQ_WATCHDOG_EN is defined
module seq_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // count consecutive stalled memory cycles; any non-stalled cycle restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // the TIMEOUT-th stalled cycle expires; mem_ready on that cycle clears waiting and wins
  assign expired = waiting && (wait_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - CPU state register with wait states, run/step parking, halt and retire count; watchdog under CPU_SEQ_WATCHDOG_EN
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_sequencer_if.slave        bus
);

  cpu_state_e       state_q, state_d;
  logic             step_q, step_d;
  logic             fault_q, fault_d;
  logic             idle_q, halted_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req;
  logic             advance;
  logic             wd_expired;

`ifdef CPU_SEQ_WATCHDOG_EN
  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (mem_req && !bus.mem_ready),
    .expired (wd_expired)
  );
`else
  wire unused_timeout = (TIMEOUT != 0);
  assign wd_expired = 1'b0;
`endif

  // memory strobe and the datapath write-enable gate, both from the current state
  always_comb begin
    mem_req = (state_q == FETCH) || (state_q == MEMORY);
    advance = 1'b0;
    case (state_q)
      FETCH, MEMORY:               advance = bus.mem_ready;
      DECODE, EXECUTE, WRITEBACK:  advance = 1'b1;
      default:                     advance = 1'b0;
    endcase
  end

  // next state, step flag, sticky fault and retire counter
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = FETCH;
        end else if (bus.step) begin
          state_d = FETCH;
          step_d  = 1'b1;
        end
      end
      HALT_STATE: begin
        state_d = HALT_STATE;
      end
      FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK: begin
        if (advance && (bus.halt || bus.next_state == HALT_STATE)) begin
          state_d = HALT_STATE;
        end else if (advance && bus.next_state == ILLEGAL) begin
          state_d = HALT_STATE;
          fault_d = 1'b1;
        end else if (wd_expired) begin
          state_d = HALT_STATE;
          fault_d = 1'b1;
        end else if (advance && bus.next_state == FETCH) begin
          cnt_d = cnt_q + 1'b1;
          if (!bus.run || step_q) begin
            state_d = IDLE;
            step_d  = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end else if (advance) begin
          state_d = cpu_state_e'(bus.next_state);
        end
      end
      default: begin
        // 111 can never be loaded; treat a corrupted register as a fault
        state_d = HALT_STATE;
        fault_d = 1'b1;
      end
    endcase
  end

  // state and status registers; reset parks the core in IDLE at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      step_q   <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
      idle_q   <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
      idle_q   <= (state_d == IDLE);
      halted_q <= (state_d == HALT_STATE);
    end
  end

  assign bus.state       = state_q;
  assign bus.mem_req     = mem_req;
  assign bus.advance     = advance;
  assign bus.idle        = idle_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with a stub control unit
module tb_cpu_sequencer;

  localparam logic [2:0] S_FETCH = 3'b000;
  localparam logic [2:0] S_DEC   = 3'b001;
  localparam logic [2:0] S_EXE   = 3'b010;
  localparam logic [2:0] S_MEM   = 3'b011;
  localparam logic [2:0] S_WB    = 3'b100;
  localparam logic [2:0] S_HALT  = 3'b101;
  localparam logic [2:0] S_IDLE  = 3'b110;

  typedef struct {
    logic        run, step, halt, mr, mem, ill;
    logic [23:0] ev;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic use_mem = 1'b0;
  logic ill = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  cpu_sequencer_if #(.CNT_W(16)) bus ();

  cpu_sequencer #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // stub control unit: F->D->E->(M)->W->F, optional illegal code out of DECODE
  always_comb begin
    case (bus.state)
      S_FETCH: bus.next_state = S_DEC;
      S_DEC:   bus.next_state = ill ? 3'b111 : S_EXE;
      S_EXE:   bus.next_state = use_mem ? S_MEM : S_WB;
      S_MEM:   bus.next_state = S_WB;
      S_WB:    bus.next_state = S_FETCH;
      default: bus.next_state = S_FETCH;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic push(input logic r, s, h, mr, mem, il, input logic [2:0] st,
                      input logic adv, mreq, input logic [15:0] cnt, input logic flt);
    exp_t e;
    e.run = r; e.step = s; e.halt = h; e.mr = mr; e.mem = mem; e.ill = il;
    e.ev = {st, adv, mreq, flt, st == S_IDLE, st == S_HALT, cnt};
    sb.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.run = 1'b0; bus.step = 1'b0; bus.halt = 1'b0; bus.mem_ready = 1'b1;
    use_mem = 1'b0; ill = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.run = 1'b1; bus.step = 1'b1; bus.halt = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state got %b expected %b", bus.state, S_IDLE); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b expected 1", bus.idle); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", bus.halted); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b expected 0", bus.fault); end
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.instr_count); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b expected 0", bus.mem_req); end
    checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL reset_advance got %b expected 0", bus.advance); end
  endtask

  task automatic test_free_run;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,0,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,0,0, S_DEC,   1,0, 0, 0);
    push(1,0,0,1,0,0, S_EXE,   1,0, 0, 0);
    push(1,0,0,1,0,0, S_WB,    1,0, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 1, 0);
    push(1,0,0,1,0,0, S_DEC,   1,0, 1, 0);
    push(1,0,0,1,0,0, S_EXE,   1,0, 1, 0);
    push(1,0,0,1,0,0, S_WB,    1,0, 1, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 2, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL free_run cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_mem_wait;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,0,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,0,0,0, S_FETCH, 0,1, 0, 0);
    push(1,0,0,0,0,0, S_FETCH, 0,1, 0, 0);
    push(1,0,0,0,0,0, S_FETCH, 0,1, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,0,0, S_DEC,   1,0, 0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL mem_wait cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_park_step;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,0,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,0,0, S_DEC,   1,0, 0, 0);
    push(0,0,0,1,0,0, S_EXE,   1,0, 0, 0);
    push(0,0,0,1,0,0, S_WB,    1,0, 0, 0);
    push(0,0,0,1,0,0, S_IDLE,  0,0, 1, 0);
    push(0,1,0,1,0,0, S_IDLE,  0,0, 1, 0);
    push(0,0,0,1,0,0, S_FETCH, 1,1, 1, 0);
    push(0,1,0,1,0,0, S_DEC,   1,0, 1, 0);
    push(1,0,0,1,0,0, S_EXE,   1,0, 1, 0);
    push(1,0,0,1,0,0, S_WB,    1,0, 1, 0);
    push(0,0,0,1,0,0, S_IDLE,  0,0, 2, 0);
    push(0,0,0,1,0,0, S_IDLE,  0,0, 2, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL park_step cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_halt;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,0,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,0,0, S_DEC,   1,0, 0, 0);
    push(1,0,1,1,0,0, S_EXE,   1,0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      push(i[0], i[1], 0, i[2], 0, 0, S_HALT, 0,0, 0, 0);
    end
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL halt cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL halt_exit_state got %b expected %b", bus.state, S_IDLE); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_exit_halted got %b expected 0", bus.halted); end
  endtask

  task automatic test_illegal;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,0,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,1,0,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,0,1, S_DEC,   1,0, 0, 0);
    push(1,0,0,1,0,0, S_HALT,  0,0, 0, 1);
    push(0,1,0,1,0,0, S_HALT,  0,0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL illegal cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset_mid_memory;
    exp_t e; logic [23:0] obs; int cyc;
    do_reset();
    push(1,0,0,1,1,0, S_IDLE,  0,0, 0, 0);
    push(1,0,0,1,1,0, S_FETCH, 1,1, 0, 0);
    push(1,0,0,1,1,0, S_DEC,   1,0, 0, 0);
    push(1,0,0,1,1,0, S_EXE,   1,0, 0, 0);
    push(1,0,0,0,1,0, S_MEM,   0,1, 0, 0);
    push(1,0,0,0,1,0, S_MEM,   0,1, 0, 0);
    push(1,0,0,1,1,0, S_MEM,   1,1, 0, 0);
    push(1,0,0,1,1,0, S_WB,    1,0, 0, 0);
    push(1,0,0,1,1,0, S_FETCH, 1,1, 1, 0);
    push(1,0,0,1,1,0, S_DEC,   1,0, 1, 0);
    push(1,0,0,1,1,0, S_EXE,   1,0, 1, 0);
    push(1,0,0,0,1,0, S_MEM,   0,1, 1, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
      #1;
      obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
      checks++;
      if (obs !== e.ev) begin
        errors++;
        $display("FAIL mid_memory cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                 cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL async_reset_state got %b expected %b", bus.state, S_IDLE); end
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL async_reset_count got %0d expected 0", bus.instr_count); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL async_reset_mem_req got %b expected 0", bus.mem_req); end
  endtask

`ifdef CPU_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    exp_t e; logic [23:0] obs; int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      push(1,0,0,1,1,0, S_IDLE,  0,0, 0, 0);
      push(1,0,0,1,1,0, S_FETCH, 1,1, 0, 0);
      push(1,0,0,1,1,0, S_DEC,   1,0, 0, 0);
      push(1,0,0,1,1,0, S_EXE,   1,0, 0, 0);
      for (int i = 0; i < 7; i++) push(1,0,0,0,1,0, S_MEM, 0,1, 0, 0);
      if (pass == 0) begin
        push(1,0,0,0,1,0, S_MEM,   0,1, 0, 0);
        push(1,0,0,1,1,0, S_HALT,  0,0, 0, 1);
      end else begin
        push(1,0,0,1,1,0, S_MEM,   1,1, 0, 0);
        push(1,0,0,1,1,0, S_WB,    1,0, 0, 0);
        push(1,0,0,1,1,0, S_FETCH, 1,1, 1, 0);
      end
      cyc = 0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        bus.run = e.run; bus.step = e.step; bus.halt = e.halt; bus.mem_ready = e.mr; use_mem = e.mem; ill = e.ill;
        #1;
        obs = {bus.state, bus.advance, bus.mem_req, bus.fault, bus.idle, bus.halted, bus.instr_count};
        checks++;
        if (obs !== e.ev) begin
          errors++;
          $display("FAIL watchdog pass %0d cyc %0d got state=%b adv/mreq/fault/idle/halted=%b count=%0d expected state=%b flags=%b count=%0d",
                   pass, cyc, obs[23:21], obs[20:16], obs[15:0], e.ev[23:21], e.ev[20:16], e.ev[15:0]);
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask
`endif

  initial begin
    bus.run = 1'b0; bus.step = 1'b0; bus.halt = 1'b0; bus.mem_ready = 1'b1;
    test_reset();
    test_free_run();
    test_mem_wait();
    test_park_step();
    test_halt();
    test_illegal();
    test_reset_mid_memory();
`ifdef CPU_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Owns the CPU's FSM state register. The combinational `control_unit` decodes the current state and instruction into `next_state` and datapath strobes. `cpu_sequencer` decides when that state may advance. It inserts memory wait states, parks the core in IDLE for debug run/step control, latches HALT, and counts retired instructions.

## Interface
- `TIMEOUT`, 8: maximum wait cycles in FETCH/MEMORY before a fault (watchdog builds only).
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `next_state`  in  3  proposed next state from `control_unit`.
- `halt`  in  1  halt request from `control_unit`.
- `mem_ready`  in  1  memory has completed the current access.
- `run`  in  1  level; 1 = free-run, 0 = park at the next instruction boundary.
- `step`  in  1  one-cycle pulse; executes one instruction while parked.
- `state`  out  3  registered current state, driven to `control_unit`.
- `mem_req`  out  1  memory access in progress (combinational).
- `advance`  out  1  state updates this cycle; the datapath gates every write-enable with it (combinational).
- `idle`, `halted`, `fault`  out  1 each  registered status flags.
- `instr_count`  out  CNT_W  count of retired instructions.

## Operation
- State encodings: FETCH 000, DECODE 001, EXECUTE 010, MEMORY 011, WRITEBACK 100, HALT_STATE 101, IDLE 110. Code 111 is illegal.
- `mem_req` = 1 in FETCH and MEMORY.
- `advance`:
  - FETCH/MEMORY: equals `mem_ready`.
  - DECODE/EXECUTE/WRITEBACK: 1.
  - IDLE, HALT_STATE: 0.
- Transitions, highest priority first:
  1. `halt`=1 or `next_state`=HALT_STATE while in an active state, gated by `advance` → HALT_STATE.
  2. `next_state`=111, gated by `advance` → HALT_STATE with `fault`=1.
  3. Watchdog expiry → HALT_STATE with `fault`=1.
  4. `advance` with `next_state`=FETCH is an instruction boundary:
     - `instr_count` increments (wraps modulo 2^CNT_W).
     - Go to IDLE if `run`=0 or the instruction was a single step; otherwise go to FETCH.
  5. Any other `advance` → `next_state`.
  6. No `advance` → hold the current state.
- IDLE:
  - `run`=1 → FETCH.
  - `step`=1 → FETCH and set the internal step flag; the flag clears at that instruction's boundary.
  - `step` pulses outside IDLE are ignored. `run` takes precedence over `step`.
- HALT_STATE is absorbing. `run`, `step` and `mem_ready` are ignored; only `reset` exits.
- `run` falling mid-instruction never aborts it; the core always parks at the boundary.
- `idle` = (state == IDLE); `halted` = (state == HALT_STATE). `fault` is sticky until reset.

## Timing
- Reset values:
  - `state`=IDLE, `idle`=1, `halted`=0, `fault`=0, `instr_count`=0.
  - `mem_req`=0 and `advance`=0, following from the IDLE state.
- Reset is asynchronous: an assertion mid-instruction forces IDLE immediately, with no memory cycle completion.
- Latency: one clock per state when `mem_ready`=1, e.g. IDLE→FETCH→DECODE→EXECUTE→WRITEBACK→FETCH. Each low cycle of `mem_ready` adds one cycle.
- A `halt` sampled in an active state produces HALT_STATE on the next edge.

## Configuration
- `CPU_SEQ_WATCHDOG_EN` defined:
  - A wait counter increments on each FETCH/MEMORY cycle with `mem_ready`=0 and clears on `advance`.
  - When the counter reaches TIMEOUT with `mem_ready` still 0, the next state is HALT_STATE and `fault`=1.
  - `mem_ready`=1 on the expiry cycle wins: the core advances normally.
- Undefined: waits are unbounded, and `fault` is set only by the illegal `next_state` 111.

## Structure
- Package `cpu_pkg`: state localparams FETCH…IDLE, `STATE_W`=3.
- Sub-module `seq_wait_timer`: watchdog counter plus expiry flag. It is instantiated only under `CPU_SEQ_WATCHDOG_EN`.

## Test plan
- Free-run:
  - Stimulus: `reset` released, `run`=1, `mem_ready`=1, stub cycling FETCH→DECODE→EXECUTE→WRITEBACK→FETCH.
  - Required: states 110,000,001,010,100,000; `instr_count`=1 after the WRITEBACK edge; `advance`=1 throughout.
- Memory wait:
  - Stimulus: `mem_ready`=0 for 3 cycles in FETCH.
  - Required: FETCH held 4 cycles, `mem_req`=1 and `advance`=0 for 3 cycles, then DECODE.
- Park and step:
  - Stimulus: `run`→0 during EXECUTE, then one `step` pulse.
  - Required: WRITEBACK→IDLE with `instr_count`+1; after the step, one full instruction runs, IDLE again, `instr_count`+1. A second `step` during the stepped instruction is ignored.
- Halt:
  - Stimulus: `halt`=1 in EXECUTE, then `run`/`step` toggled for 20 cycles.
  - Required: `state`=101 and `halted`=1 on the next edge, unchanged for all 20 cycles; `reset` low → IDLE.
- Watchdog (macro on, TIMEOUT=8):
  - `mem_ready`=0 in MEMORY → HALT_STATE and `fault`=1 after 8 wait cycles.
  - Same, but `mem_ready`=1 on cycle 8 → normal advance, `fault`=0.
- Illegal and reset:
  - `next_state`=111 in DECODE → HALT_STATE with `fault`=1.
  - `reset` low mid-MEMORY → `state`=110, `instr_count`=0, `mem_req`=0 before the next clock edge.
